// File: rtl/eth_mii_pkg.sv
// Shared MII definitions: FSM encoding, nibble-counter width and the output word.
// Combinational only, no latency or backpressure of its own.
package eth_mii_pkg;

  localparam int NIB_CNT_W = 7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LO    = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_ERR   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  typedef struct packed {
    logic       underrun;
    logic       tx_en;
    logic       tx_er;
    logic [3:0] txd;
  } mii_out_t;

  localparam mii_out_t MII_OUT_IDLE = '0;

  // The counter runs from this value down to zero, so the gap is 2*ifg_bytes cycles.
  function automatic logic [NIB_CNT_W-1:0] gap_load(input int ifg_bytes);
    return NIB_CNT_W'(2 * ifg_bytes - 1);
  endfunction

  function automatic mii_out_t mii_nib(input logic er, input logic [3:0] txd, input logic pulse);
    mii_out_t o;
    o.underrun = pulse;
    o.tx_en    = 1'b1;
    o.tx_er    = er;
    o.txd      = txd;
    return o;
  endfunction

endpackage

// File: rtl/mii_tx_nibble_if.sv
// Byte-stream handshake into the MII transmitter (tdata/tvalid/tready/tlast/tuser).
// Signal bundle only; tready is the sole backpressure path.
interface mii_tx_nibble_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/ssio_sdr_out_reg.sv
// Single-data-rate output register, one clk of latency, no backpressure.
// TARGET only steers how vendor flows place the flop; behaviour is identical.
module ssio_sdr_out_reg #(
  parameter string TARGET = "GENERIC",
  parameter int    WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (TARGET == "SIM") begin : g_sim
      always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= d;
      end
    end else begin : g_fabric
      // Plain reset mux so vendor flows can pack the flop into the I/O cell.
      always_ff @(posedge clk) begin
        q <= rst ? '0 : d;
      end
    end
  endgenerate

endmodule

// File: rtl/mii_tx_nibble.sv
// Byte stream to MII nibbles: low nibble 1 cycle after accept, high nibble 2 cycles after.
// tready derives from state only; starvation mid-frame aborts with an error burst, then drain and gap.
module mii_tx_nibble
  import eth_mii_pkg::*;
#(
  parameter string TARGET    = "GENERIC",
  parameter int    IFG_BYTES = 12
) (
  input  logic           clk,
  input  logic           rst,
  mii_tx_nibble_if.slave s_axis,
  output logic [3:0]     mii_txd,
  output logic           mii_tx_en,
  output logic           mii_tx_er,
  output logic           underrun
);

  localparam logic [NIB_CNT_W-1:0] GAP_LOAD = gap_load(IFG_BYTES);

  logic [2:0]           state_q, state_d;
  logic [NIB_CNT_W-1:0] gap_cnt_q;
  logic                 err_first_q;
  logic [3:0]           cur_hi_q;
  logic                 cur_er_q;
  logic                 cur_last_q;
  logic [7:0]           nxt_dat_q;
  logic                 nxt_er_q;
  logic                 nxt_last_q;
  logic                 nxt_vld_q;
  logic                 accept;
  mii_out_t             out_d;
  mii_out_t             out_q;

  // LO is the only slot where the following byte can be taken without a bubble.
  assign s_axis.tready = (state_q == ST_IDLE) || (state_q == ST_DRAIN) ||
                         ((state_q == ST_LO) && !cur_last_q);
  assign accept        = s_axis.tvalid && s_axis.tready;

  always_comb begin
    state_d = state_q;
    out_d   = MII_OUT_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_d   = mii_nib(s_axis.tuser, s_axis.tdata[3:0], 1'b0);
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        out_d   = mii_nib(cur_er_q, cur_hi_q, 1'b0);
        state_d = ST_HI;
      end
      ST_HI: begin
        if (nxt_vld_q) begin
          out_d   = mii_nib(nxt_er_q, nxt_dat_q[3:0], 1'b0);
          state_d = ST_LO;
        end else if (cur_last_q) begin
          state_d = ST_GAP;
        end else begin
          out_d   = mii_nib(1'b1, 4'h0, 1'b1);
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        if (err_first_q) out_d   = mii_nib(1'b1, 4'h0, 1'b0);
        else             state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept && s_axis.tlast) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_GAP;
      gap_cnt_q   <= GAP_LOAD;
      err_first_q <= 1'b0;
      cur_hi_q    <= 4'h0;
      cur_er_q    <= 1'b0;
      cur_last_q  <= 1'b0;
      nxt_dat_q   <= 8'h00;
      nxt_er_q    <= 1'b0;
      nxt_last_q  <= 1'b0;
      nxt_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_first_q <= (state_q == ST_HI) && (state_d == ST_ERR);

      if ((state_d == ST_GAP) && (state_q != ST_GAP))
        gap_cnt_q <= GAP_LOAD;
      else if ((state_q == ST_GAP) && (gap_cnt_q != '0))
        gap_cnt_q <= gap_cnt_q - NIB_CNT_W'(1);

      if ((state_q == ST_IDLE) && accept) begin
        cur_hi_q   <= s_axis.tdata[7:4];
        cur_er_q   <= s_axis.tuser;
        cur_last_q <= s_axis.tlast;
      end else if ((state_q == ST_HI) && nxt_vld_q) begin
        cur_hi_q   <= nxt_dat_q[7:4];
        cur_er_q   <= nxt_er_q;
        cur_last_q <= nxt_last_q;
      end

      if ((state_q == ST_LO) && accept) begin
        nxt_dat_q  <= s_axis.tdata;
        nxt_er_q   <= s_axis.tuser;
        nxt_last_q <= s_axis.tlast;
        nxt_vld_q  <= 1'b1;
      end else if (state_q == ST_HI) begin
        nxt_vld_q  <= 1'b0;
      end
    end
  end

  ssio_sdr_out_reg #(
    .TARGET (TARGET),
    .WIDTH  ($bits(mii_out_t))
  ) u_out_reg (
    .clk (clk),
    .rst (rst),
    .d   (out_d),
    .q   (out_q)
  );

  assign mii_txd   = out_q.txd;
  assign mii_tx_en = out_q.tx_en;
  assign mii_tx_er = out_q.tx_er;
  assign underrun  = out_q.underrun;

endmodule

// File: tb/tb_mii_tx_nibble.sv
// Directed and randomized frames against a frame-level model of the MII nibble stream.
module tb_mii_tx_nibble;

  localparam int IFG  = 12;
  localparam int GAPC = 2 * IFG;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mii_txd;
  logic       mii_tx_en, mii_tx_er, underrun;

  mii_tx_nibble_if s_axis();

  mii_tx_nibble #(.TARGET("SIM"), .IFG_BYTES(IFG)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_axis),
    .mii_txd   (mii_txd),
    .mii_tx_en (mii_tx_en),
    .mii_tx_er (mii_tx_er),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       un;
    logic       en;
    logic       er;
    logic [3:0] txd;
    logic       rdy;
    logic       acc;
    logic       lst;
  } smp_t;

  smp_t        log_q[$];
  logic        logging = 1'b0;
  logic [9:0]  txq[$];       // {tuser, tlast, tdata} offered in order
  logic [4:0]  exp_nib[$];   // {tx_er, txd} expected on every tx_en cycle
  int          exp_blen[$];  // expected tx_en burst lengths
  int          b_start[$], b_len[$];
  int          n_assert = 0, n_fail = 0;

  always @(negedge clk)
    if (logging)
      log_q.push_back('{underrun, mii_tx_en, mii_tx_er, mii_txd, s_axis.tready,
                        s_axis.tvalid & s_axis.tready, s_axis.tlast});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void add_byte(input logic [7:0] d, input logic u, input logic l);
    txq.push_back({u, l, d});
    exp_nib.push_back({u, d[3:0]});
    exp_nib.push_back({u, d[7:4]});
  endfunction

  function automatic void scan();
    b_start.delete();
    b_len.delete();
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].en && (i == 0 || !log_q[i-1].en)) begin
        b_start.push_back(i);
        b_len.push_back(1);
      end else if (log_q[i].en) begin
        b_len[b_len.size()-1] = b_len[b_len.size()-1] + 1;
      end
    end
  endfunction

  function automatic int count_underrun();
    int n = 0;
    for (int i = 0; i < log_q.size(); i++) n += int'(log_q[i].un);
    return n;
  endfunction

  task automatic push_all(input int budget);
    int waited = 0;
    while (txq.size() > 0 && waited < budget) begin
      {s_axis.tuser, s_axis.tlast, s_axis.tdata} = txq[0];
      s_axis.tvalid = 1'b1;
      @(negedge clk);
      if (s_axis.tready) void'(txq.pop_front());
      @(posedge clk);
      #1;
      waited++;
    end
    s_axis.tvalid = 1'b0;
    chk("push_timeout", txq.size(), 0);
    txq.delete();
  endtask

  task automatic check_stream(input string tag);
    int j = 0;
    scan();
    chk({tag, "_bursts"}, b_start.size(), exp_blen.size());
    for (int k = 0; k < b_start.size() && k < exp_blen.size(); k++) begin
      chk({tag, "_len"}, b_len[k], exp_blen[k]);
      for (int c = 0; c < b_len[k]; c++) begin
        if (j < exp_nib.size())
          chk({tag, "_nib"}, {log_q[b_start[k]+c].er, log_q[b_start[k]+c].txd}, exp_nib[j]);
        j++;
      end
    end
  endtask

  task automatic new_scenario();
    log_q.delete();
    exp_nib.delete();
    exp_blen.delete();
  endtask

  initial begin
    int n, pos, e, rdy_cnt, t_last, r_idx, seen;
    logic [7:0] d;

    rst = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", mii_txd, 0);
    chk("rst_tx_en", mii_tx_en, 0);
    chk("rst_tx_er", mii_tx_er, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_tready", s_axis.tready, 0);

    // Back-to-back frames with tvalid held: preamble-like frame, tuser byte, single byte, random.
    add_byte(8'h55, 1'b0, 1'b0);
    add_byte(8'hD5, 1'b0, 1'b0);
    add_byte(8'hA1, 1'b0, 1'b1);
    exp_blen.push_back(6);
    n   = int'($urandom_range(3, 6));
    pos = int'($urandom_range(1, n - 2));
    for (int i = 0; i < n; i++) begin
      if (i == pos) add_byte(8'h3C, 1'b1, 1'b0);
      else          add_byte(8'($urandom), 1'b0, i == n - 1);
    end
    exp_blen.push_back(2 * n);
    add_byte(8'hF0, 1'b0, 1'b1);
    exp_blen.push_back(2);
    n = int'($urandom_range(1, 5));
    for (int i = 0; i < n; i++) add_byte(8'($urandom), 1'($urandom_range(0, 1)), i == n - 1);
    exp_blen.push_back(2 * n);

    @(posedge clk);
    #1;
    rst = 1'b0;
    logging = 1'b1;
    push_all(1000);
    repeat (GAPC + 12) @(posedge clk);
    #1;
    check_stream("A");
    if (b_start.size() > 0) chk("A_first_after_rst", b_start[0], GAPC + 1);
    for (int k = 1; k < b_start.size(); k++) begin
      e = b_start[k-1] + b_len[k-1];
      chk("A_ifg", b_start[k] - e, GAPC + 1);
      rdy_cnt = 0;
      for (int c = e; c < e + GAPC; c++) rdy_cnt += int'(log_q[c].rdy);
      chk("A_gap_tready", rdy_cnt, 0);
      chk("A_idle_tready", log_q[e + GAPC].rdy, 1);
    end
    chk("A_underrun", count_underrun(), 0);

    // Starvation after byte 2 of a 5-byte frame, then a fresh single-byte frame.
    new_scenario();
    add_byte(8'($urandom), 1'b0, 1'b0);
    add_byte(8'($urandom), 1'b0, 1'b0);
    exp_nib.push_back(5'h10);
    exp_nib.push_back(5'h10);
    exp_blen.push_back(6);
    push_all(100);
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) txq.push_back({1'b0, i == 2, 8'($urandom)});
    push_all(100);
    d = 8'($urandom);
    add_byte(d, 1'b0, 1'b1);
    exp_blen.push_back(2);
    push_all(200);
    repeat (GAPC + 12) @(posedge clk);
    #1;
    check_stream("B");
    chk("B_underrun_count", count_underrun(), 1);
    if (b_start.size() > 0) chk("B_underrun_pos", log_q[b_start[0] + 4].un, 1);
    t_last = -1;
    for (int i = 0; i < log_q.size(); i++)
      if (t_last < 0 && log_q[i].acc && log_q[i].lst) t_last = i;
    if (b_start.size() >= 2) chk("B_drain_gap", b_start[1] - t_last, GAPC + 2);

    // Reset pulsed during the 3rd nibble; the frame is dropped and the gap restarts.
    new_scenario();
    d = 8'($urandom);
    add_byte(d, 1'b0, 1'b0);
    d = 8'($urandom);
    txq.push_back({1'b1, 1'b0, d});
    exp_nib.push_back({1'b1, d[3:0]});
    txq.push_back({1'b0, 1'b1, 8'($urandom)});
    exp_blen.push_back(3);
    r_idx = 0;
    fork
      push_all(100);
      begin
        seen = 0;
        for (int c = 0; c < 100 && seen < 3; c++) begin
          @(negedge clk);
          if (mii_tx_en) seen++;
        end
        chk("C_reach_3rd_nibble", seen, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        r_idx = log_q.size();
        @(negedge clk);
        chk("C_rst_tx_en", mii_tx_en, 0);
        chk("C_rst_txd", mii_txd, 0);
        chk("C_rst_tx_er", mii_tx_er, 0);
        chk("C_rst_underrun", underrun, 0);
        chk("C_rst_tready", s_axis.tready, 0);
      end
    join
    d = 8'($urandom);
    add_byte(d, 1'($urandom_range(0, 1)), 1'b1);
    exp_blen.push_back(2);
    push_all(200);
    repeat (GAPC + 12) @(posedge clk);
    #1;
    check_stream("C");
    if (b_start.size() >= 2) chk("C_restart_gap", b_start[1] - r_idx, GAPC + 1);
    chk("C_underrun", count_underrun(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
